mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported memory between the instruction-fetch requester and the load/store requester of the RV32 core. It sits between the core and the unified memory. It arbitrates between the two requesters and issues one access at a time. It counts a fixed memory latency and returns each read result, or each write completion, to the requester that owns the access. Only one transaction is outstanding at a time, and a new issue may overlap the completion cycle of the previous one.

## Interface
Parameters:
- MEM_LATENCY, 2, cycles from the issue cycle to the cycle `mem_rdata` is valid; legal range 1..15
- ADDR_W, 32, address width

Ports:
- SYS_clk  in  1  clock; one clock, all state updates on its rising edge
- SYS_reset  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held with `if_addr` stable until `if_gnt`
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid, 1-cycle pulse
- if_rdata  out  32  fetch data; 0 when `if_rvalid`=0
- d_req  in  1  data request; held with all `d_*` fields stable until `d_gnt`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_length  in  2  access length: 01 byte, 10 half, 11 word, 00 none
- d_signed  in  1  load sign-extension select
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid or store complete, 1-cycle pulse
- d_rdata  out  32  load data; 0 for stores and when `d_rvalid`=0
- mem_en  out  1  memory access issued this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  32  write data
- mem_length  out  2  access length, same encoding as `d_length`
- mem_signed  out  1  read sign-extension select
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after issue
- busy  out  1  a transaction is outstanding

## Operation
States:
- IDLE: no transaction outstanding.
- WAIT: a transaction is outstanding. A 4-bit counter `cnt` and an owner register `own` (IF or D) record it.

Issue:
- Issue is allowed when the state is IDLE, or when the state is WAIT with `cnt`==1 (the completion cycle).
- In an issue cycle with at least one request:
  - the winner's `*_gnt` is set combinationally;
  - `mem_en`=1 and the `mem_*` fields are copied from the winner;
  - the next state is WAIT, with `cnt`=MEM_LATENCY and `own`=winner.
- Fetch issue: `mem_we`=0, `mem_length`=11, `mem_signed`=0.

Completion:
- In WAIT, `cnt` decrements each cycle.
- When `cnt`==1:
  - the owner's `*_rvalid`=1;
  - the owner's `*_rdata`=`mem_rdata` for reads, 0 for stores;
  - the state goes to IDLE, unless a new issue happens in the same cycle.

Default arbitration is fixed priority: data wins over fetch, because the data access belongs to the older instruction.

Idle outputs:
- When `mem_en`=0, every `mem_*` output is 0.
- `busy` = (state==WAIT).

Boundaries:
- `d_length`=00 with `d_req`=1: granted normally, but `mem_en` is held 0. `d_rvalid` still pulses MEM_LATENCY cycles later, with `d_rdata`=0.
- Misaligned addresses pass through unchanged.
- A request that is not granted is not latched. The requester keeps `req` asserted.
- Deasserting `req` before grant withdraws the request. This is legal and has no side effects.
- SYS_reset in any state aborts the outstanding transaction: no `rvalid` is ever produced for it, the state goes to IDLE, `cnt`=0, `own`=D.

## Timing
- Reset value of every output is 0. Next state is IDLE, `cnt`=0, `own`=D, and round-robin pointer `last`=D.
- Grant-to-data latency is exactly MEM_LATENCY cycles. An issue in cycle T gives `rvalid` in cycle T+MEM_LATENCY.
- Throughput is one access per MEM_LATENCY cycles. With MEM_LATENCY=1, one access per cycle is sustained.
- `*_gnt` and `mem_*` are combinational from `*_req` and the registered state. `*_rvalid` and `*_rdata` are combinational from the registered state and `mem_rdata`.
- `if_gnt` and `d_gnt` are never both 1 in a cycle. `if_rvalid` and `d_rvalid` are never both 1 in a cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - when both requests arrive in an issue cycle, the requester that did not win the previous contested issue wins;
  - `last` updates only on contested issues;
  - after reset, fetch wins the first contest.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data always wins contests, and there is no `last` register.

## Test plan
- MEM_LATENCY=2; `if_req`=1 alone with `if_addr`=0x0 at cycle 0; memory model returns 0x00500413 → cycle 0: `if_gnt`=1, `mem_en`=1, `mem_addr`=0. Cycle 2: `if_rvalid`=1, `if_rdata`=0x00500413, `busy`=0 at cycle 3.
- Fixed priority; `if_req` and `d_req` (lw, `d_addr`=0x100) both at cycle 0 → cycle 0: `d_gnt`=1. Cycle 2: `d_rvalid`=1 and `if_gnt`=1 together. Cycle 4: `if_rvalid`=1.
- ARB_ROUND_ROBIN_EN; both requests held through 4 issues → grant order IF, D, IF, D at cycles 0, 2, 4, 6.
- Store: `d_we`=1, `d_length`=01, `d_addr`=0x203, `d_wdata`=0xAB → `mem_we`=1, `mem_length`=01, `mem_addr`=0x203, `mem_wdata`=0xAB. Cycle 2: `d_rvalid`=1, `d_rdata`=0. `if_rvalid` stays 0 throughout.
- Load issued at cycle 0; SYS_reset=1 at cycle 1 → cycle 2: all outputs 0, `busy`=0. No `d_rvalid` at cycle 2 or later.
- MEM_LATENCY=1; `if_req` held for 3 cycles with addresses 0x0, 0x4, 0x8 → `if_gnt`=1 in cycles 0–2. `if_rvalid`=1 in cycles 1–3 with data in order.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch (if_*) and
//   load/store (d_*) requesters of the RV32 core. One transaction is
//   outstanding at a time. Read data or a store completion is returned to the
//   owner exactly MEM_LATENCY cycles after issue. A new issue may overlap the
//   completion cycle of the previous access.
//
// Parameters
//   MEM_LATENCY  cycles from issue to valid mem_rdata (1..15)
//   ADDR_W       address width
//
// Ports
//   SYS_clk, SYS_reset        clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt  fetch request / combinational grant
//   if_rvalid/if_rdata        fetch data return (1-cycle pulse)
//   d_req/d_we/d_addr/d_wdata/d_length/d_signed -> d_gnt
//                             load/store request / combinational grant
//   d_rvalid/d_rdata          load data or store completion (1-cycle pulse)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_length/mem_signed
//                             memory access, all zero when mem_en=0
//   mem_rdata                 memory read data, valid MEM_LATENCY after issue
//   busy                      a transaction is outstanding
//
// Build option
//   ARB_ROUND_ROBIN_EN  contested issues alternate between the requesters
//                       (fetch wins the first contest after reset). When not
//                       defined, data always wins contests.
//
// States
//   IDLE | no transaction outstanding
//   WAIT | transaction outstanding, cnt counts down to the completion cycle

module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_length,
  input  logic              d_signed,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_length,
  output logic              mem_signed,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
  typedef enum logic {OWN_D = 1'b0, OWN_IF = 1'b1} own_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  own_e       own_q, own_d;
  // rd_q: the outstanding access returns memory data (fetch or sized load);
  // stores and zero-length accesses return 0.
  logic       rd_q, rd_d;
`ifdef ARB_ROUND_ROBIN_EN
  own_e       last_q, last_d;
`endif

  logic done;
  logic can_issue;
  logic pick_if;

  assign done      = (state_q == ST_WAIT) && (cnt_q == 4'd1);
  // Reset blocks issue and return in its own cycle so an aborted access
  // never shows a pulse and every output reads 0 while reset is held.
  assign can_issue = !SYS_reset && ((state_q == ST_IDLE) || done);

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_if = if_req && (!d_req || (last_q == OWN_D));
`else
  assign pick_if = if_req && !d_req;
`endif

  assign busy = (state_q == ST_WAIT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_d      = own_q;
    rd_d       = rd_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_length = 2'b00;
    mem_signed = 1'b0;

    if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      if (done) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (!SYS_reset) begin
          if (own_q == OWN_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = rd_q ? mem_rdata : 32'd0;
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = rd_q ? mem_rdata : 32'd0;
          end
        end
      end
    end

    if (can_issue && (if_req || d_req)) begin
      state_d = ST_WAIT;
      cnt_d   = CNT_INIT;
`ifdef ARB_ROUND_ROBIN_EN
      if (if_req && d_req) last_d = pick_if ? OWN_IF : OWN_D;
`endif
      if (pick_if) begin
        if_gnt     = 1'b1;
        own_d      = OWN_IF;
        rd_d       = 1'b1;
        mem_en     = 1'b1;
        mem_addr   = if_addr;
        mem_length = 2'b11;
      end else begin
        d_gnt = 1'b1;
        own_d = OWN_D;
        rd_d  = !d_we && (d_length != 2'b00);
        // Zero-length access: granted and completed on schedule, but the
        // memory is never touched.
        if (d_length != 2'b00) begin
          mem_en     = 1'b1;
          mem_we     = d_we;
          mem_addr   = d_addr;
          mem_wdata  = d_wdata;
          mem_length = d_length;
          mem_signed = d_signed;
        end
      end
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      own_q   <= OWN_D;
      rd_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= OWN_D;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      rd_q    <= rd_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule
